// File: rtl/ssp_receiver.sv
// SSP frame receiver: samples the peer's serial clock/sync/data in the
// pclk domain, assembles MSB-first words and pushes them into the RX FIFO.
// Reports overruns (sticky) and mid-word sync framing errors (pulse).
module ssp_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  clear,
    input  logic                  sspclkin,
    input  logic                  sspfssin,
    input  logic                  ssprxd,
    input  logic                  rxfifoint,
    output logic                  rxfifowrite,
    output logic [DATA_WIDTH-1:0] rxdata,
    output logic                  rxoverrun,
    output logic                  rxframeerr,
    output logic                  rxbusy
);

    localparam int               CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           bitcnt;
    logic [CW-1:0]           bitcnt_nxt;
    // The shift register only keeps DATA_WIDTH-1 bits: the final bit is
    // taken straight from ssprxd when the word completes.
    logic [DATA_WIDTH-2:0]   sr;
    logic [DATA_WIDTH-2:0]   sr_nxt;
    logic [DATA_WIDTH-1:0]   word;
    logic                    clk_q;
    logic                    fall;
    logic                    write_nxt;
    logic                    overrun_set;
    logic                    frameerr_nxt;

    // Falling edge of the sampled serial clock; clk_q resets low so no
    // spurious edge appears when reset is released.
    assign fall = clk_q & ~sspclkin;
    assign word = {sr, ssprxd};

    // Next-state, bit counter, shift register and event decode.
    always_comb begin
        state_nxt    = state;
        bitcnt_nxt   = bitcnt;
        sr_nxt       = sr;
        write_nxt    = 1'b0;
        overrun_set  = 1'b0;
        frameerr_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (fall && sspfssin) begin
                    state_nxt  = SHIFT;
                    bitcnt_nxt = '0;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (bitcnt == LAST) begin
                        // Word complete; a sync on this same edge starts the
                        // next frame without a gap.
                        sr_nxt     = word[DATA_WIDTH-2:0];
                        bitcnt_nxt = '0;
                        if (rxfifoint) begin
                            overrun_set = 1'b1;
                        end else begin
                            write_nxt   = 1'b1;
                        end
                        if (sspfssin) begin
                            state_nxt = SHIFT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (sspfssin) begin
                        // Mid-word sync: drop the partial word and restart
                        // without shifting this bit in.
                        frameerr_nxt = 1'b1;
                        bitcnt_nxt   = '0;
                        sr_nxt       = '0;
                    end else begin
                        sr_nxt     = word[DATA_WIDTH-2:0];
                        bitcnt_nxt = bitcnt + CW'(1);
                    end
                end else begin
                    state_nxt = SHIFT;
                end
            end
            default: begin
                state_nxt  = IDLE;
                bitcnt_nxt = '0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            bitcnt      <= '0;
            sr          <= '0;
            clk_q       <= 1'b0;
            rxfifowrite <= 1'b0;
            rxdata      <= '0;
            rxoverrun   <= 1'b0;
            rxframeerr  <= 1'b0;
            rxbusy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            bitcnt      <= bitcnt_nxt;
            sr          <= sr_nxt;
            clk_q       <= sspclkin;
            rxfifowrite <= write_nxt;
            rxdata      <= write_nxt ? word : rxdata;
            rxoverrun   <= rxoverrun | overrun_set;
            rxframeerr  <= frameerr_nxt;
            rxbusy      <= (state_nxt == SHIFT);
        end
    end

endmodule

// File: tb/tb_ssp_receiver.sv
// Self-checking bench for ssp_receiver: directed scenarios plus a randomized
// frame stream checked against a word-level reference model.
module tb_ssp_receiver;

    logic       pclk;
    logic       clear;
    logic       sspclkin;
    logic       sspfssin;
    logic       ssprxd;
    logic       rxfifoint;
    logic       rxfifowrite;
    logic [7:0] rxdata;
    logic       rxoverrun;
    logic       rxframeerr;
    logic       rxbusy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_fall_cyc = 0;
    int         ferr_cnt = 0;
    logic       fifo_full_cfg = 1'b0;
    logic [7:0] wq_data[$];
    int         wq_cyc[$];

    ssp_receiver #(.DATA_WIDTH(8)) dut (
        .pclk        (pclk),
        .clear       (clear),
        .sspclkin    (sspclkin),
        .sspfssin    (sspfssin),
        .ssprxd      (ssprxd),
        .rxfifoint   (rxfifoint),
        .rxfifowrite (rxfifowrite),
        .rxdata      (rxdata),
        .rxoverrun   (rxoverrun),
        .rxframeerr  (rxframeerr),
        .rxbusy      (rxbusy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Record every FIFO write and frame-error pulse away from the active edge.
    always @(negedge pclk) begin
        if (clear === 1'b0) begin
            if (rxfifowrite !== 1'b0) begin
                wq_data.push_back(rxdata);
                wq_cyc.push_back(cyc);
            end
            if (rxframeerr !== 1'b0) ferr_cnt++;
        end
    end

    // One sspclkin period as the peer drives it: rise (new data), then fall.
    task automatic sp(input logic fss, input logic d);
        @(posedge pclk); #1;
        sspclkin  = 1'b1;
        sspfssin  = fss;
        ssprxd    = d;
        rxfifoint = fifo_full_cfg;
        @(posedge pclk); #1;
        sspclkin  = 1'b0;
        last_fall_cyc = cyc;
    endtask

    task automatic send_word(input logic [7:0] w, input logic fss_last, output int first_fall);
        first_fall = 0;
        for (int b = 7; b >= 0; b--) begin
            sp((b == 0) ? fss_last : 1'b0, w[b]);
            if (b == 7) first_fall = last_fall_cyc;
        end
    endtask

    task automatic idle(input int n);
        sspfssin = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic clear_log();
        wq_data.delete();
        wq_cyc.delete();
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        clear = 1'b1; sspclkin = 1'b0; sspfssin = 1'b0; ssprxd = 1'b0; rxfifoint = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        n_checks++; if (rxfifowrite !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", rxfifowrite); end
        n_checks++; if (rxdata !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rxdata); end
        n_checks++; if (rxoverrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", rxoverrun); end
        n_checks++; if (rxframeerr !== 1'b0) begin n_fail++; $display("FAIL reset_frameerr: got %b want 0", rxframeerr); end
        n_checks++; if (rxbusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rxbusy); end
        clear = 1'b0;
        idle(3);
    endtask

    task automatic test_single();
        int ff;
        clear_log();
        sp(1'b1, 1'b0);
        send_word(8'hA5, 1'b0, ff);
        n_checks++; if (rxbusy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_fall: got %b want 1", rxbusy); end
        @(posedge pclk); #1;
        n_checks++; if (rxbusy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", rxbusy); end
        idle(4);
        n_checks++; if (wq_data.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", wq_data.size()); end
        else begin
            n_checks++; if (wq_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", wq_data[0]); end
            n_checks++; if (wq_cyc[0] - ff !== 15) begin n_fail++; $display("FAIL single_latency: got %0d want 15", wq_cyc[0] - ff); end
        end
        n_checks++; if (rxoverrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b want 0", rxoverrun); end
    endtask

    task automatic test_back_to_back();
        int f1, f2;
        clear_log();
        sp(1'b1, 1'b0);
        send_word(8'h3C, 1'b1, f1);
        send_word(8'hC3, 1'b0, f2);
        idle(4);
        n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", wq_data.size()); end
        else begin
            n_checks++; if (wq_data[0] !== 8'h3C || wq_data[1] !== 8'hC3) begin
                n_fail++; $display("FAIL b2b_data: got %h %h want 3c c3", wq_data[0], wq_data[1]);
            end
            n_checks++; if (wq_cyc[1] - wq_cyc[0] !== 16) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 16", wq_cyc[1] - wq_cyc[0]); end
        end
    endtask

    task automatic test_fifo_full();
        int ff;
        clear_log();
        fifo_full_cfg = 1'b1;
        sp(1'b1, 1'b0);
        send_word(8'h5A, 1'b0, ff);
        idle(4);
        fifo_full_cfg = 1'b0;
        n_checks++; if (wq_data.size() !== 0) begin n_fail++; $display("FAIL full_no_write: got %0d writes want 0", wq_data.size()); end
        n_checks++; if (rxoverrun !== 1'b1) begin n_fail++; $display("FAIL full_overrun: got %b want 1", rxoverrun); end
        n_checks++; if (rxdata !== 8'hC3) begin n_fail++; $display("FAIL full_data_held: got %h want c3", rxdata); end
        sp(1'b1, 1'b0);
        send_word(8'h11, 1'b0, ff);
        idle(4);
        n_checks++; if (wq_data.size() !== 1 || rxdata !== 8'h11) begin
            n_fail++; $display("FAIL full_next_write: got %0d writes data %h want 1 writes data 11", wq_data.size(), rxdata);
        end
        n_checks++; if (rxoverrun !== 1'b1) begin n_fail++; $display("FAIL full_overrun_sticky: got %b want 1", rxoverrun); end
    endtask

    task automatic test_frame_err();
        int ff;
        clear_log();
        sp(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) sp(1'b0, 1'($urandom_range(1, 0)));
        sp(1'b1, 1'($urandom_range(1, 0)));
        send_word(8'h81, 1'b0, ff);
        idle(4);
        n_checks++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
        n_checks++; if (wq_data.size() !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", wq_data.size()); end
        else begin
            n_checks++; if (wq_data[0] !== 8'h81) begin n_fail++; $display("FAIL ferr_data: got %h want 81", wq_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int ff;
        clear_log();
        sp(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sp(1'b0, 1'b1);
        #2 clear = 1'b1;
        #1;
        n_checks++; if ({rxfifowrite, rxdata, rxoverrun, rxframeerr, rxbusy} !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_outputs: got w=%b d=%h o=%b e=%b b=%b want all 0",
                               rxfifowrite, rxdata, rxoverrun, rxframeerr, rxbusy);
        end
        repeat (2) @(posedge pclk);
        #1 clear = 1'b0;
        idle(2);
        sp(1'b1, 1'b0);
        send_word(8'h0F, 1'b0, ff);
        idle(4);
        n_checks++; if (wq_data.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", wq_data.size()); end
        else begin
            n_checks++; if (wq_data[0] !== 8'h0F) begin n_fail++; $display("FAIL rstmid_data: got %h want 0f", wq_data[0]); end
        end
        n_checks++; if (rxoverrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b want 0", rxoverrun); end
    endtask

    task automatic test_idle_noise();
        int busy_seen = 0;
        clear_log();
        for (int i = 0; i < 20; i++) begin
            sp(1'b0, 1'($urandom_range(1, 0)));
            if (rxbusy !== 1'b0) busy_seen++;
        end
        idle(4);
        n_checks++; if (wq_data.size() !== 0) begin n_fail++; $display("FAIL noise_writes: got %0d want 0", wq_data.size()); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL noise_busy: got %0d busy samples want 0", busy_seen); end
    endtask

    // Random frame stream; the model only tracks which words must reach the
    // FIFO, whether any was dropped, and the last word delivered.
    task automatic test_random();
        localparam int N = 12;
        logic [7:0] words[N];
        logic       full[N];
        logic       b2b[N];
        logic [7:0] exp_q[$];
        logic       exp_ovr;
        logic [7:0] exp_last;
        int         ff;
        clear_log();
        exp_ovr  = 1'b0;
        exp_last = 8'h0F;
        for (int i = 0; i < N; i++) begin
            words[i] = 8'($urandom);
            full[i]  = ($urandom_range(3, 0) == 0);
            b2b[i]   = (i > 0) && ($urandom_range(1, 0) == 1);
            if (full[i]) exp_ovr = 1'b1;
            else begin exp_q.push_back(words[i]); exp_last = words[i]; end
        end
        for (int i = 0; i < N; i++) begin
            fifo_full_cfg = full[i];
            if (!b2b[i]) begin
                idle($urandom_range(3, 1));
                sp(1'b1, 1'b0);
            end
            send_word(words[i], (i < N - 1) ? b2b[i + 1] : 1'b0, ff);
        end
        fifo_full_cfg = 1'b0;
        idle(4);
        n_checks++; if (wq_data.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d want %0d", wq_data.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++; if (wq_data[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, wq_data[i], exp_q[i]);
                end
            end
        end
        n_checks++; if (rxoverrun !== exp_ovr) begin n_fail++; $display("FAIL rand_overrun: got %b want %b", rxoverrun, exp_ovr); end
        n_checks++; if (rxdata !== exp_last) begin n_fail++; $display("FAIL rand_last_data: got %h want %h", rxdata, exp_last); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_frame_err();
        test_reset_mid();
        test_idle_noise();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
